mem_responder: RTL and testbench

Memory-side responder for the CPU's memory bus. It decodes `mem_cmd`/`mem_addr` from the CPU, services reads and writes against a 256-word on-chip RAM and two memory-mapped I/O words (switches, LEDs), and returns read data plus a one-cycle `mem_ready` strobe after a configurable number of wait states. It sits between the CPU's `mem_cmd`/`mem_addr`/`out` outputs and its `in` read-data input.

---
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// CPU memory bus bundle: command/address/store data out, load data and ready strobe back.
// The CPU side drives through the master modport; the responder uses the slave modport.
// The CPU holds cmd/addr/data until it sees mem_ready and drops cmd in the cycle after.
interface mem_responder_if;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        mem_ready;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data,
    input  mem_ready
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data,
    output mem_ready
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: 256-word RAM plus switch/LED I/O words behind the CPU memory bus.
// Latency: WAIT_STATES+1 edges from the command-sampling edge to the mem_ready cycle.
// Backpressure: no queueing; commands are only sampled in IDLE, ignored in WAIT/RESPOND.
module mem_responder #(
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  input  logic [7:0]           sw,
  output logic [7:0]           led,
  output logic                 err
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_BAD   = 2'b11;

  localparam logic [8:0] ADDR_SW  = 9'h100;
  localparam logic [8:0] ADDR_LED = 9'h101;

  // First value of the wait counter; the last WAIT cycle is the one with counter 0.
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic [1:0]  r_cmd;
  logic [8:0]  r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [7:0]  r_led;
  logic        r_err;
  logic [15:0] r_ram [0:255];

  logic        w_latch;
  logic        w_enter_rsp;
  logic        w_bad_cmd;

  logic [1:0]  w_acc_cmd;
  logic [8:0]  w_acc_addr;
  logic [15:0] w_acc_wdata;
  logic        w_is_ram;
  logic        w_is_sw;
  logic        w_is_led;
  logic        w_is_rd;
  logic        w_is_wr;
  logic [15:0] w_rd_word;
  logic        w_acc_err;
  logic        w_ram_we;

  // Access operands: live bus values when the access completes straight out of IDLE
  // (WAIT_STATES=0), otherwise the copy latched when the command was accepted.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_cmd   = bus.mem_cmd;
      w_acc_addr  = bus.mem_addr;
      w_acc_wdata = bus.write_data;
    end else begin
      w_acc_cmd   = r_cmd;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
    end
  end

  assign w_is_ram = ~w_acc_addr[8];
  assign w_is_sw  = (w_acc_addr == ADDR_SW);
  assign w_is_led = (w_acc_addr == ADDR_LED);
  assign w_is_rd  = (w_acc_cmd == CMD_READ);
  assign w_is_wr  = (w_acc_cmd == CMD_WRITE);

  // Read mux over the address map; unmapped space reads as zero.
  always_comb begin
    w_rd_word = 16'h0000;
    if (w_is_ram) begin
      w_rd_word = r_ram[w_acc_addr[7:0]];
    end else if (w_is_sw) begin
      w_rd_word = {8'h00, sw};
    end else if (w_is_led) begin
      w_rd_word = {8'h00, r_led};
    end
  end

  // Reads of unmapped space and writes to anything but RAM/LED are flagged.
  always_comb begin
    w_acc_err = 1'b0;
    if (w_is_rd) begin
      w_acc_err = ~(w_is_ram | w_is_sw | w_is_led);
    end else if (w_is_wr) begin
      w_acc_err = ~(w_is_ram | w_is_led);
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESPOND.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_enter_rsp = 1'b0;
    w_bad_cmd   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.mem_cmd == CMD_READ || bus.mem_cmd == CMD_WRITE) begin
          w_latch = 1'b1;
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_RESPOND;
            w_enter_rsp = 1'b1;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end else if (bus.mem_cmd == CMD_BAD) begin
          w_bad_cmd = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_RESPOND;
          w_enter_rsp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESPOND: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State and wait counter; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the accepted command so the bus is don't-care during WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd   <= CMD_NONE;
      r_addr  <= 9'h000;
      r_wdata <= 16'h0000;
    end else if (w_latch) begin
      r_cmd   <= bus.mem_cmd;
      r_addr  <= bus.mem_addr;
      r_wdata <= bus.write_data;
    end
  end

  // Response-edge side effects: load data, LED store, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 16'h0000;
      r_led   <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      if (w_bad_cmd) begin
        r_err <= 1'b1;
      end
      if (w_enter_rsp) begin
        if (w_is_rd) begin
          r_rdata <= w_rd_word;
        end
        if (w_is_wr && w_is_led) begin
          r_led <= w_acc_wdata[7:0];
        end
        if (w_acc_err) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // RAM store commits on the response edge; held off while reset is asserted.
  assign w_ram_we = w_enter_rsp & w_is_wr & w_is_ram & ~reset;

  // RAM array has no reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_acc_addr[7:0]] <= w_acc_wdata;
    end
  end

  assign bus.read_data = r_rdata;
  assign bus.mem_ready = (r_state == S_RESPOND);
  assign led           = r_led;
  assign err           = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_STATES=2 and 0) against a behavioural model.
// Directed steps for the documented scenarios, then randomized accesses.
// Every access checks latency, load data, LED and error flag.
module tb_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] led0, led2;
  logic       err0, err2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus2 ();

  mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .sw(sw), .led(led0), .err(err0)
  );
  mem_responder #(.WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .sw(sw), .led(led2), .err(err2)
  );

  // Reference model; index 0 is the WAIT_STATES=0 instance, 1 the WAIT_STATES=2 one.
  logic [15:0] m_ram   [2][256];
  bit          m_known [2][256];
  logic [7:0]  m_led   [2];
  bit          m_err   [2];
  logic [15:0] m_rd    [2];
  bit          m_rd_ok [2];

  function automatic int ws_of(int d);
    return (d == 1) ? 2 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
    if (d == 1) begin
      bus2.mem_cmd = c; bus2.mem_addr = a; bus2.write_data = w;
    end else begin
      bus0.mem_cmd = c; bus0.mem_addr = a; bus0.write_data = w;
    end
  endtask

  function automatic logic rdy_of(int d);
    return (d == 1) ? bus2.mem_ready : bus0.mem_ready;
  endfunction
  function automatic logic [15:0] rd_of(int d);
    return (d == 1) ? bus2.read_data : bus0.read_data;
  endfunction
  function automatic logic [7:0] led_of(int d);
    return (d == 1) ? led2 : led0;
  endfunction
  function automatic logic err_of(int d);
    return (d == 1) ? err2 : err0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_led[d] = 8'h00; m_err[d] = 1'b0; m_rd[d] = 16'h0000; m_rd_ok[d] = 1'b1;
    end
  endtask

  // Address-map behaviour of one completed access.
  task automatic model_apply(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w);
    if (c == 2'b01) begin
      m_rd_ok[d] = 1'b1;
      if (a < 9'd256) begin
        m_rd[d] = m_ram[d][a[7:0]];
        m_rd_ok[d] = m_known[d][a[7:0]];
      end else if (a == 9'h100) m_rd[d] = {8'h00, sw};
      else if (a == 9'h101) m_rd[d] = {8'h00, m_led[d]};
      else begin m_rd[d] = 16'h0000; m_err[d] = 1'b1; end
    end else if (c == 2'b10) begin
      if (a < 9'd256) begin m_ram[d][a[7:0]] = w; m_known[d][a[7:0]] = 1'b1; end
      else if (a == 9'h101) m_led[d] = w[7:0];
      else m_err[d] = 1'b1;
    end
  endtask

  // Wait for mem_ready with a bound; returns the number of edges from drive to ready.
  task automatic wait_ready(input int d, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (rdy_of(d) === 1'b1) got = 1'b1;
    end
    if (!got) lat = 99;
  endtask

  task automatic check_outputs(input int d, input string tag);
    if (m_rd_ok[d]) chk({tag, "_rdata"}, 32'(rd_of(d)), 32'(m_rd[d]));
    chk({tag, "_led"}, 32'(led_of(d)), 32'(m_led[d]));
    chk({tag, "_err"}, 32'(err_of(d)), 32'(m_err[d]));
  endtask

  // One full access: drive, measure latency, compare, drop cmd, confirm single pulse.
  task automatic access(input int d, input logic [1:0] c, input logic [8:0] a,
                        input logic [15:0] w, input string tag);
    int lat;
    drive(d, c, a, w);
    wait_ready(d, lat);
    model_apply(d, c, a, w);
    chk({tag, "_lat"}, 32'(lat), 32'(ws_of(d) + 1));
    check_outputs(d, tag);
    drive(d, 2'b00, a, w);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(rdy_of(d)), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [8:0] a;
    logic [15:0] prior;

    reset = 1'b1;
    sw    = 8'h00;
    drive(0, 2'b00, 9'h000, 16'h0000);
    drive(1, 2'b00, 9'h000, 16'h0000);
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) m_known[d][i] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready2", 32'(bus2.mem_ready), 32'd0);
    chk("rst_ready0", 32'(bus0.mem_ready), 32'd0);
    chk("rst_rdata2", 32'(bus2.read_data), 32'h0);
    chk("rst_led2", 32'(led2), 32'h0);
    chk("rst_err0", 32'(err0), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Known contents for the low RAM words used by random traffic.
    for (int i = 0; i < 32; i++) begin
      access(0, 2'b10, 9'(i), 16'($urandom), "fill0");
      access(1, 2'b10, 9'(i), 16'($urandom), "fill2");
    end

    // WAIT_STATES=2: store then load.
    access(1, 2'b10, 9'h005, 16'hBEEF, "ws2_wr");
    access(1, 2'b01, 9'h005, 16'h0000, "ws2_rd");
    chk("ws2_beef", 32'(bus2.read_data), 32'h0000BEEF);

    // WAIT_STATES=0: switch read.
    sw = 8'hA5;
    access(0, 2'b01, 9'h100, 16'h0000, "ws0_sw");
    chk("ws0_sw_a5", 32'(bus0.read_data), 32'h000000A5);

    // LED write then readback.
    access(0, 2'b10, 9'h101, 16'h1234, "led_wr");
    chk("led_34", 32'(led0), 32'h34);
    access(0, 2'b01, 9'h101, 16'h0000, "led_rd");
    chk("led_rd_34", 32'(bus0.read_data), 32'h00000034);

    // Unmapped read, then invalid command while idle.
    access(0, 2'b01, 9'h1F0, 16'h0000, "unmap_rd");
    chk("unmap_err", 32'(err0), 32'd1);
    drive(0, 2'b11, 9'h000, 16'h0000);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus0.mem_ready === 1'b1) pulses++;
    end
    drive(0, 2'b00, 9'h000, 16'h0000);
    chk("bad_cmd_noready", 32'(pulses), 32'd0);
    chk("bad_cmd_err", 32'(err0), 32'd1);

    // Reset in the middle of a write's wait states.
    access(1, 2'b10, 9'h010, 16'h0F0F, "pre_wr");
    prior = 16'h0F0F;
    drive(1, 2'b10, 9'h010, 16'h5555);
    @(posedge clk); #1;
    chk("abort_wait_ready", 32'(bus2.mem_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_async_ready", 32'(bus2.mem_ready), 32'd0);
    drive(1, 2'b00, 9'h000, 16'h0000);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus2.mem_ready === 1'b1) pulses++;
    end
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus2.mem_ready === 1'b1) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    chk("abort_err0_cleared", 32'(err0), 32'd0);
    chk("abort_led0_cleared", 32'(led0), 32'h0);
    chk("abort_rdata2_cleared", 32'(bus2.read_data), 32'h0);
    access(1, 2'b01, 9'h010, 16'h0000, "abort_rd");
    chk("abort_prior", 32'(bus2.read_data), 32'(prior));

    // Command held through RESPOND, dropped in the following cycle.
    drive(1, 2'b01, 9'h005, 16'h0000);
    wait_ready(1, lat);
    model_apply(1, 2'b01, 9'h005, 16'h0000);
    chk("hold_lat", 32'(lat), 32'd3);
    @(posedge clk); #1;
    pulses = (bus2.mem_ready === 1'b1) ? 1 : 0;
    drive(1, 2'b00, 9'h005, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus2.mem_ready === 1'b1) pulses++;
    end
    chk("hold_single_pulse", 32'(pulses), 32'd0);
    check_outputs(1, "hold");

    // Random traffic over RAM, I/O and unmapped space on both instances.
    for (int n = 0; n < 60; n++) begin
      int d;
      int sel;
      logic [1:0] c;
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 7));
      c   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      if (sel <= 4)      a = 9'($urandom_range(0, 31));
      else if (sel == 5) a = 9'h100;
      else if (sel == 6) a = 9'h101;
      else               a = 9'($urandom_range(9'h102, 9'h1FF));
      sw = 8'($urandom);
      access(d, c, a, 16'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop in case something stalls the directed sequence.
  initial begin
    #400000;
    $display("FAIL timeout observed=stalled expected=finished");
    $fatal(1, "timeout");
  end

endmodule
